// File: rtl/wave_asin_if.sv
// wave_asin_if -- request/result and sine-table signals for wave_asin.
//
//   start      request strobe, sampled only while the search is idle
//   target     requested height (0..768 meaningful, larger values clamp)
//   quadrant   half-period selector for the returned index
//   rom_index  index presented to the shared sine table (bits [10:8] zero)
//   rom_value  table output for rom_index, combinational in the same cycle
//   busy       search in progress
//   done       single-cycle result strobe
//   c_index    in-quadrant result
//   index_out  full-period index 0..1023
//   sat        target was above 768 and got clamped
//
// The master side is the surroundings of the search: the requester plus
// the shared table, which answers rom_index with rom_value.
`timescale 1ns/1ps
interface wave_asin_if;
  logic        start;
  logic [9:0]  target;
  logic [1:0]  quadrant;
  logic [10:0] rom_index;
  logic [9:0]  rom_value;
  logic        busy;
  logic        done;
  logic [7:0]  c_index;
  logic [10:0] index_out;
  logic        sat;

  modport master (
    output start, target, quadrant, rom_value,
    input  rom_index, busy, done, c_index, index_out, sat
  );

  modport slave (
    input  start, target, quadrant, rom_value,
    output rom_index, busy, done, c_index, index_out, sat
  );
endinterface

// File: rtl/wave_asin.sv
// wave_asin -- inverse sine lookup by MSB-first binary search.
//
// Given a height and a quadrant, returns the first wave index at which the
// quarter-wave sine table reaches that height, mapped onto the full period.
// One table probe per cycle, 8 probes, then a one-cycle DONE strobe.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; aborts a running search
//   bus    wave_asin_if.slave (start/target/quadrant in, table probe
//          rom_index/rom_value, busy/done/c_index/index_out/sat out)
//
// Build option: define WAVE_ASIN_NEAREST_EN to add one NEAR cycle that
// rounds the result to the closer of table(ans-1) and table(ans); latency
// grows from 9 to 10 cycles. Without it the result is the lower bound.
`timescale 1ns/1ps
module wave_asin (
  input  logic         clk,
  input  logic         rst_n,
  wave_asin_if.slave   bus
);

`ifdef WAVE_ASIN_NEAREST_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PROBE = 2'd1, S_DONE = 2'd2, S_NEAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PROBE = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t      state, state_nxt;
  logic [2:0]  bit_idx;
  logic [7:0]  ans, ans_nxt;
  logic [9:0]  tgt;
  logic [1:0]  q;
  logic        sat_r;
  logic [7:0]  probe_t;
  logic [7:0]  rom_idx8;
  logic        hit;
  logic        fin;
  logic        accept;
  logic [7:0]  c_index_r;
  logic [10:0] index_out_r;
  logic        sat_o;
`ifdef WAVE_ASIN_NEAREST_EN
  logic [9:0]  v1;
  logic        near_lo;
`endif

  function automatic logic [9:0] clamp_tgt(input logic [9:0] x);
    return (x > 10'd768) ? 10'd768 : x;
  endfunction

  // Fold the in-quadrant result onto the 1024-entry period; q3 wraps so
  // that c = 0 lands on index 0 rather than 1024.
  function automatic logic [10:0] quad_map(input logic [1:0] qq, input logic [7:0] c);
    logic [10:0] c11;
    c11 = {3'b000, c};
    case (qq)
      2'd0:    return c11;
      2'd1:    return 11'd512 - c11;
      2'd2:    return 11'd512 + c11;
      default: return (11'd1024 - c11) & 11'h3FF;
    endcase
  endfunction

  assign accept  = (state == S_IDLE) && bus.start;
  // Candidate answer for this bit; the probe checks table(t-1) < tgt,
  // i.e. whether at least t entries lie below the target. t is never 0.
  assign probe_t = ans | (8'd1 << bit_idx);
  assign hit     = bus.rom_value < tgt;
`ifdef WAVE_ASIN_NEAREST_EN
  // table(ans-1) < tgt <= table(ans), so both differences are non-negative.
  assign near_lo = (tgt - bus.rom_value) < (v1 - tgt);
`endif

  always_comb begin
    state_nxt = state;
    ans_nxt   = ans;
    rom_idx8  = 8'd0;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_PROBE;
      end
      S_PROBE: begin
        rom_idx8 = probe_t - 8'd1;
        if (hit) ans_nxt = probe_t;
        if (bit_idx == 3'd0) begin
`ifdef WAVE_ASIN_NEAREST_EN
          state_nxt = S_NEAR;
`else
          state_nxt = S_DONE;
          fin       = 1'b1;
`endif
        end
      end
`ifdef WAVE_ASIN_NEAREST_EN
      S_NEAR: begin
        // Spent even when ans = 0 so the latency stays fixed.
        if (ans != 8'd0) begin
          rom_idx8 = ans - 8'd1;
          if (near_lo) ans_nxt = ans - 8'd1;
        end
        state_nxt = S_DONE;
        fin       = 1'b1;
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_idx     <= 3'd7;
      c_index_r   <= 8'd0;
      index_out_r <= 11'd0;
      sat_o       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_PROBE) bit_idx <= bit_idx - 3'd1;
      else                  bit_idx <= 3'd7;
      if (fin) begin
        c_index_r   <= ans_nxt;
        index_out_r <= quad_map(q, ans_nxt);
        sat_o       <= sat_r;
      end
    end
  end

  // Search datapath; only meaningful between accept and DONE
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt   <= clamp_tgt(bus.target);
      sat_r <= bus.target > 10'd768;
      q     <= bus.quadrant;
      ans   <= 8'd0;
`ifdef WAVE_ASIN_NEAREST_EN
      v1    <= 10'd768;
`endif
    end else begin
      ans <= ans_nxt;
`ifdef WAVE_ASIN_NEAREST_EN
      // The last failing probe is exactly index ans, so it leaves table(ans)
      // here; ans = 255 never fails a probe and keeps table(255) = 768.
      if (state == S_PROBE && !hit) v1 <= bus.rom_value;
`endif
    end
  end

  assign bus.rom_index = {3'b000, rom_idx8};
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.c_index   = c_index_r;
  assign bus.index_out = index_out_r;
  assign bus.sat       = sat_o;

endmodule

// File: tb/tb_wave_asin.sv
// tb_wave_asin -- self-checking bench for wave_asin.
// Table of directed vectors plus random requests; expected results go to a
// scoreboard queue on accept and are checked when done strobes.
`timescale 1ns/1ps
module tb_wave_asin;

`ifdef WAVE_ASIN_NEAREST_EN
  localparam int DONE_EDGES = 9;
`else
  localparam int DONE_EDGES = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_asin_if bus();

  wave_asin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tbl [256];
  assign bus.rom_value = 10'(tbl[bus.rom_index[7:0]]);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int idx; int sat; int acc;} exp_t;
  exp_t sbq[$];

  typedef struct {int tgt; int q; int c; int idx; int sat;} vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: count table entries below the clamped target.
  function automatic int model_c(input int t);
    int tt;
    int a;
    tt = (t > 768) ? 768 : t;
    a = 0;
    for (int i = 0; i < 256; i++) if (tbl[i] < tt) a++;
`ifdef WAVE_ASIN_NEAREST_EN
    if (a > 0 && (tt - tbl[a-1]) < (tbl[a] - tt)) a--;
`endif
    return a;
  endfunction

  function automatic int model_idx(input int qd, input int c);
    case (qd)
      0:       return c;
      1:       return 512 - c;
      2:       return 512 + c;
      default: return (1024 - c) % 1024;
    endcase
  endfunction

  // Result monitor
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("rom_hi_bits", int'(bus.rom_index[10:8]), 0);
      if (!bus.busy) check("rom_idle", int'(bus.rom_index), 0);
      check("done_pair", int'(prev_done & bus.done), 0);
      if (bus.done) begin
        if (sbq.size() == 0) begin
          fail_now("spurious_done");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("c_index", int'(bus.c_index), e.c);
          check("index_out", int'(bus.index_out), e.idx);
          check("sat", int'(bus.sat), e.sat);
          check("latency", cyc - e.acc, DONE_EDGES);
          check("busy_in_done", int'(bus.busy), 1);
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Called at posedge+2; waits for idle, then requests one search.
  task automatic req(input int t, input int qd, input int ec, input int ei, input int es);
    int n;
    exp_t e;
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (bus.busy) fail_now("idle_timeout");
    bus.start    = 1'b1;
    bus.target   = 10'(t);
    bus.quadrant = 2'(qd);
    @(posedge clk); #1;
    e.c = ec; e.idx = ei; e.sat = es; e.acc = cyc;
    sbq.push_back(e);
    #1;
    bus.start  = 1'b0;
    bus.target = 10'($urandom_range(0, 1023));
  endtask

  task automatic req_model(input int t, input int qd);
    int c;
    c = model_c(t);
    req(t, qd, c, model_idx(qd, c), (t > 768) ? 1 : 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (sbq.size() != 0) begin
      fail_now("drain_timeout");
      sbq.delete();
    end
  endtask

  initial begin
    int n;
    int t;
    int qd;
    bus.start    = 1'b0;
    bus.target   = 10'd0;
    bus.quadrant = 2'd0;
    for (int i = 0; i < 256; i++)
      tbl[i] = $rtoi(768.0 * $sin(3.14159265358979 * i / 512.0) + 0.5);

    vecs[0] = '{0,    0, 0,   0,   0};
`ifdef WAVE_ASIN_NEAREST_EN
    vecs[1] = '{300,  0, 65,  65,  0};
`else
    vecs[1] = '{300,  0, 66,  66,  0};
`endif
    vecs[2] = '{768,  1, 251, 261, 0};
    vecs[3] = '{767,  3, 246, 778, 0};
    vecs[4] = '{1000, 2, 251, 763, 1};
    vecs[5] = '{0,    3, 0,   0,   0};
    vecs[6] = '{769,  0, 251, 251, 1};
    vecs[7] = '{1023, 3, 251, 773, 1};

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_c_index", int'(bus.c_index), 0);
    check("rst_index_out", int'(bus.index_out), 0);
    check("rst_sat", int'(bus.sat), 0);
    check("rst_rom_index", int'(bus.rom_index), 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Directed vectors, issued back to back
    for (int i = 0; i < 8; i++)
      req(vecs[i].tgt, vecs[i].q, vecs[i].c, vecs[i].idx, vecs[i].sat);
    drain();

    // Random requests against the reference
    for (int i = 0; i < 16; i++) begin
      t  = $urandom_range(0, 1023);
      qd = $urandom_range(0, 3);
      req_model(t, qd);
    end
    drain();

    // Start pulses and input toggling while busy are ignored
    req_model(300, 0);
    for (int i = 0; i < 8; i++) begin
      bus.start    = 1'($urandom_range(0, 1));
      bus.target   = 10'($urandom_range(0, 1023));
      bus.quadrant = 2'($urandom_range(0, 3));
      @(posedge clk); #2;
    end
    bus.start = 1'b0;
    drain();

    // Start held through the done cycle: accepted only the cycle after
    req_model(500, 1);
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) fail_now("done_timeout");
    bus.start    = 1'b1;
    bus.target   = 10'd200;
    bus.quadrant = 2'd2;
    @(posedge clk); #1;
    check("no_accept_in_done", int'(bus.busy), 0);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.c = model_c(200); e.idx = model_idx(2, e.c); e.sat = 0; e.acc = cyc;
      sbq.push_back(e);
    end
    check("accept_after_done", int'(bus.busy), 1);
    #1;
    bus.start = 1'b0;
    drain();

    // Reset during the fourth probe aborts the search
    req_model(600, 3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_c_index", int'(bus.c_index), 0);
    check("abort_index_out", int'(bus.index_out), 0);
    check("abort_sat", int'(bus.sat), 0);
    check("abort_rom_index", int'(bus.rom_index), 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    req_model(600, 3);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_asin.md
# wave_asin

Inverse sine lookup for the surfer physics path: given a wave height (0..768, the sine-table scale) and a quadrant, it returns the horizontal wave index (0..1023) at which the wave first reaches that height. It runs a fixed-latency, MSB-first binary search, one table probe per cycle, against the shared combinational sine table. It sits between the surfer-height logic and the wave renderer, which needs the phase that matches a given height.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only when idle.
- `target`  in  10  requested height; captured on an accepted `start`.
- `quadrant`  in  2  half-period selector; captured on an accepted `start`.
- `rom_index`  out  11  index to the sine table; bits [10:8] are always 0.
- `rom_value`  in  10  table output for `rom_index`, combinational in the same cycle.
- `busy`  out  1  search in progress.
- `done`  out  1  single-cycle result strobe.
- `c_index`  out  8  in-quadrant result.
- `index_out`  out  11  full-period index, 0..1023.
- `sat`  out  1  set when `target` > 768 (clamped).

## Operation
- Table contract: `rom_value` = table(`rom_index`), nondecreasing over 0..255, table(255) = 768.
- States:
  - IDLE → PROBE when `start` = 1.
  - PROBE runs for 8 cycles, bit b = 7..0.
  - Optional NEAR: 1 cycle, see Configuration.
  - DONE: 1 cycle, then back to IDLE.
- Capture on the accepting edge:
  - `tgt` = min(`target`, 768).
  - `sat_r` = (`target` > 768).
  - `q` = `quadrant`.
  - `ans` = 0.
- PROBE bit b:
  - t = `ans` | (1<<b).
  - `rom_index` = t − 1, driven from registers.
  - If `rom_value` < `tgt`, then `ans` ← t.
- Result: `ans` = count of entries with table(i) < `tgt`, which is the smallest i with table(i) ≥ `tgt`. Range is 0..255.
- Quadrant map for result c:
  - q = 0 → c
  - q = 1 → 512 − c
  - q = 2 → 512 + c
  - q = 3 → (1024 − c) mod 1024, so c = 0 maps to 0.
- `index_out` arithmetic is 11-bit unsigned. No intermediate overflow is possible.
- `start` while `busy` is ignored; no queuing.
- `target`/`quadrant` changes after capture have no effect on the running search.
- Outputs `c_index`, `index_out` and `sat` update only in the DONE cycle and hold until the next DONE.
- `rom_index` = 0 whenever not in PROBE/NEAR.

## Timing
- Reset values: `busy` = 0, `done` = 0, `c_index` = 0, `index_out` = 0, `sat` = 0, `rom_index` = 0, state IDLE.
- Reset mid-search aborts immediately. No `done` is produced, and outputs return to their reset values.
- Timeline, with `start` sampled at edge E0:
  - `busy` = 1 from E0 through the end of DONE.
  - Probes occupy cycles E0..E8.
  - `done` = 1 and results valid in cycle E8..E9 (latency 9 cycles).
- `busy` falls together with `done`.
- A `start` held high during the `done` cycle is not accepted. The earliest accept is the cycle after `done`, giving back-to-back throughput of 1 result per 10 cycles.
- `done` never asserts for two consecutive cycles.

## Configuration
- `WAVE_ASIN_NEAREST_EN` defined:
  - After PROBE, if `ans` > 0, one NEAR cycle probes `rom_index` = `ans` − 1 (value v0). table(`ans`) (v1) was latched during PROBE.
  - If (`tgt` − v0) < (v1 − `tgt`), then `ans` ← `ans` − 1. Ties keep `ans`.
  - If `ans` = 0, the NEAR cycle is still spent, keeping fixed latency; `rom_index` = 0.
  - Latency becomes 10 cycles.
- Undefined: lower-bound result, 9-cycle latency, no NEAR state.

## Test plan
- Reset release, `target` = 0, `quadrant` = 0, `start` → `done` 9 cycles later; `c_index` = 0, `index_out` = 0, `sat` = 0.
- `target` = 300, q0 (table(65) = 298, table(66) = 303) → `c_index` = 66, `index_out` = 66. With `WAVE_ASIN_NEAREST_EN`: `c_index` = 65, latency 10.
- `target` = 768, q1 → `c_index` = 251, `index_out` = 261. `target` = 767, q3 → `c_index` = 246, `index_out` = 778.
- `target` = 1000, q2 → `sat` = 1, `c_index` = 251, `index_out` = 763. Then `target` = 0, q3 → `index_out` = 0 (wrap), `sat` = 0.
- Extra `start` pulses mid-search, plus `target` toggling during the search → ignored; a single `done` with the first request's result. A `start` in the `done` cycle is ignored; the next cycle is accepted.
- `rst_n` low at probe 4 → all outputs 0 within the same cycle, no `done`. A fresh `start` afterwards completes normally.
